// File: rtl/ps2_key_controller.sv
// PS/2 keyboard receiver: synchronises the pins, captures 11-bit frames, and tracks the nine game keys.
// Optional build macro PS2_PARITY_CHECK_EN turns on the odd-parity check in CHECK.
module ps2_key_controller #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    output logic [3:0] key_index,
    output logic       key_pressed,
    output logic [8:0] key_state,
    output logic       frame_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
    logic ps2_data_meta_q, ps2_data_sync_q;

    state_t          state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic            stop_q, stop_d;
    logic            break_pending_q, break_pending_d;
    logic            key_valid_q, key_valid_d;
    logic [3:0]      key_index_q, key_index_d;
    logic            key_pressed_q, key_pressed_d;
    logic [8:0]      key_state_q, key_state_d;
    logic            frame_err_q, frame_err_d;

    logic fall;
    logic parity_ok;
    logic key_hit;
    logic [3:0] key_idx;

    // Synchronisers reset high so a released line never looks like a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2_clk_meta_q  <= 1'b1;
            ps2_clk_sync_q  <= 1'b1;
            ps2_clk_prev_q  <= 1'b1;
            ps2_data_meta_q <= 1'b1;
            ps2_data_sync_q <= 1'b1;
        end else begin
            ps2_clk_meta_q  <= ps2_clk;
            ps2_clk_sync_q  <= ps2_clk_meta_q;
            ps2_clk_prev_q  <= ps2_clk_sync_q;
            ps2_data_meta_q <= ps2_data;
            ps2_data_sync_q <= ps2_data_meta_q;
        end
    end

    assign fall = ps2_clk_prev_q & ~ps2_clk_sync_q;

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^{shift_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        key_hit = 1'b1;
        key_idx = 4'd0;
        case (shift_q)
            8'h1C: key_idx = 4'd0;
            8'h23: key_idx = 4'd1;
            8'h24: key_idx = 4'd2;
            8'h2B: key_idx = 4'd3;
            8'h34: key_idx = 4'd4;
            8'h2D: key_idx = 4'd5;
            8'h1B: key_idx = 4'd6;
            8'h2C: key_idx = 4'd7;
            8'h1D: key_idx = 4'd8;
            default: key_hit = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        idle_cnt_d      = idle_cnt_q;
        shift_d         = shift_q;
        parity_d        = parity_q;
        stop_d          = stop_q;
        break_pending_d = break_pending_q;
        key_valid_d     = 1'b0;
        key_index_d     = key_index_q;
        key_pressed_d   = key_pressed_q;
        key_state_d     = key_state_q;
        frame_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                idle_cnt_d = '0;
                if (fall && !ps2_data_sync_q) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'd1;
                end
            end
            RECV: begin
                if (fall) begin
                    idle_cnt_d = '0;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q <= 4'd8) begin
                        shift_d = {ps2_data_sync_q, shift_q[7:1]};
                    end else if (bit_cnt_q == 4'd9) begin
                        parity_d = ps2_data_sync_q;
                    end else begin
                        stop_d  = ps2_data_sync_q;
                        state_d = CHECK;
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                    // Comparing the next value lands the strobe TIMEOUT_CYCLES after the edge.
                    if (idle_cnt_d == IDLE_LAST) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                        bit_cnt_d   = '0;
                    end
                end
            end
            CHECK: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                if (!stop_q || !parity_ok) begin
                    frame_err_d = 1'b1;
                end else if (shift_q == 8'hF0) begin
                    break_pending_d = 1'b1;
                end else if (shift_q == 8'hE0) begin
                    break_pending_d = break_pending_q;
                end else if (key_hit) begin
                    key_valid_d          = 1'b1;
                    key_index_d          = key_idx;
                    key_pressed_d        = !break_pending_q;
                    key_state_d[key_idx] = !break_pending_q;
                    break_pending_d      = 1'b0;
                end else begin
                    break_pending_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            idle_cnt_q      <= '0;
            shift_q         <= '0;
            parity_q        <= 1'b0;
            stop_q          <= 1'b0;
            break_pending_q <= 1'b0;
            key_valid_q     <= 1'b0;
            key_index_q     <= '0;
            key_pressed_q   <= 1'b0;
            key_state_q     <= '0;
            frame_err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            idle_cnt_q      <= idle_cnt_d;
            shift_q         <= shift_d;
            parity_q        <= parity_d;
            stop_q          <= stop_d;
            break_pending_q <= break_pending_d;
            key_valid_q     <= key_valid_d;
            key_index_q     <= key_index_d;
            key_pressed_q   <= key_pressed_d;
            key_state_q     <= key_state_d;
            frame_err_q     <= frame_err_d;
        end
    end

    assign key_valid   = key_valid_q;
    assign key_index   = key_index_q;
    assign key_pressed = key_pressed_q;
    assign key_state   = key_state_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed bench for ps2_key_controller: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_key_controller;

    localparam int T    = 100;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_valid;
    logic [3:0] key_index;
    logic       key_pressed;
    logic [8:0] key_state;
    logic       frame_err;

    int checks    = 0;
    int failures  = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    logic [8:0] exp_state = 9'h000;

    ps2_key_controller #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_valid  (key_valid),
        .key_index  (key_index),
        .key_pressed(key_pressed),
        .key_state  (key_state),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid === 1'b1) valid_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if (key_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    task automatic send_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(stop);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_frame(b, ~^b, 1'b1);
    endtask

    task automatic check_key(input string name, input int v0, input int e0,
                             input logic [3:0] idx, input logic pressed);
        checks++;
        if (valid_cnt - v0 !== 1) begin
            failures++;
            $display("FAIL %s valid_pulses got=%0d want=1", name, valid_cnt - v0);
        end
        checks++;
        if (err_cnt - e0 !== 0) begin
            failures++;
            $display("FAIL %s err_pulses got=%0d want=0", name, err_cnt - e0);
        end
        checks++;
        if (key_index !== idx) begin
            failures++;
            $display("FAIL %s key_index got=%0d want=%0d", name, key_index, idx);
        end
        checks++;
        if (key_pressed !== pressed) begin
            failures++;
            $display("FAIL %s key_pressed got=%0b want=%0b", name, key_pressed, pressed);
        end
        checks++;
        if (key_state !== exp_state) begin
            failures++;
            $display("FAIL %s key_state got=%h want=%h", name, key_state, exp_state);
        end
    endtask

    task automatic check_quiet(input string name, input int v0, input int e0, input int want_err);
        checks++;
        if (valid_cnt - v0 !== 0) begin
            failures++;
            $display("FAIL %s valid_pulses got=%0d want=0", name, valid_cnt - v0);
        end
        checks++;
        if (err_cnt - e0 !== want_err) begin
            failures++;
            $display("FAIL %s err_pulses got=%0d want=%0d", name, err_cnt - e0, want_err);
        end
        checks++;
        if (key_state !== exp_state) begin
            failures++;
            $display("FAIL %s key_state got=%h want=%h", name, key_state, exp_state);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({key_valid, key_index, key_pressed, key_state, frame_err} !== 16'h0000) begin
            failures++;
            $display("FAIL %s outputs got v=%b i=%0d p=%b s=%h e=%b want all zero",
                     name, key_valid, key_index, key_pressed, key_state, frame_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_all_zero("after_reset");
    endtask

    task automatic test_make();
        int v0 = valid_cnt, e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        exp_state = 9'h001;
        check_key("make_1C", v0, e0, 4'd0, 1'b1);
    endtask

    task automatic test_break();
        int v0 = valid_cnt, e0 = err_cnt;
        send_ok(8'hF0);
        check_quiet("break_F0", v0, e0, 0);
        v0 = valid_cnt; e0 = err_cnt;
        send_ok(8'h1C);
        exp_state = 9'h000;
        check_key("break_1C", v0, e0, 4'd0, 1'b0);
    endtask

    task automatic test_multi_key();
        int v0 = valid_cnt, e0 = err_cnt;
        send_ok(8'h1D);
        exp_state = 9'h100;
        check_key("make_1D", v0, e0, 4'd8, 1'b1);
        v0 = valid_cnt; e0 = err_cnt;
        send_ok(8'h23);
        exp_state = 9'h102;
        check_key("make_23", v0, e0, 4'd1, 1'b1);
        send_ok(8'hF0);
        v0 = valid_cnt; e0 = err_cnt;
        send_ok(8'h1D);
        exp_state = 9'h002;
        check_key("break_1D", v0, e0, 4'd8, 1'b0);
    endtask

    task automatic test_typematic();
        int v0 = valid_cnt, e0 = err_cnt;
        send_ok(8'h23);
        check_key("repeat_23", v0, e0, 4'd1, 1'b1);
    endtask

    task automatic test_extended_break();
        int v0 = valid_cnt, e0 = err_cnt;
        send_ok(8'hF0);
        send_ok(8'hE0);
        check_quiet("f0_e0", v0, e0, 0);
        v0 = valid_cnt; e0 = err_cnt;
        send_ok(8'h23);
        exp_state = 9'h000;
        check_key("e0_break_23", v0, e0, 4'd1, 1'b0);
        v0 = valid_cnt; e0 = err_cnt;
        send_ok(8'h55);
        check_quiet("other_byte", v0, e0, 0);
    endtask

    task automatic test_parity();
        int v0 = valid_cnt, e0 = err_cnt;
        send_frame(8'h24, 1'b0, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        check_quiet("parity_err", v0, e0, 1);
`else
        exp_state = exp_state | 9'h004;
        check_key("parity_ignored", v0, e0, 4'd2, 1'b1);
`endif
    endtask

    task automatic test_stop_err();
        int v0 = valid_cnt, e0 = err_cnt;
        send_frame(8'h2D, ~^8'h2D, 1'b0);
        check_quiet("stop_err", v0, e0, 1);
    endtask

    task automatic test_timeout();
        int v0 = valid_cnt, e0 = err_cnt;
        int first = 0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk) ps2_data = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        for (int n = 1; n <= T + 20; n++) begin
            @(posedge clk);
            #1;
            if (n == HALF) ps2_clk = 1'b1;
            if (frame_err === 1'b1 && first == 0) first = n;
        end
        checks++;
        if (first !== T + 2) begin
            failures++;
            $display("FAIL timeout_latency got=%0d want=%0d", first, T + 2);
        end
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        check_quiet("timeout_pulse", v0, e0, 1);
        v0 = valid_cnt; e0 = err_cnt;
        send_ok(8'h2B);
        exp_state = exp_state | 9'h008;
        check_key("after_timeout_2B", v0, e0, 4'd3, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        int v0 = valid_cnt, e0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("mid_reset");
        reset = 1'b0;
        repeat (2 * T) @(negedge clk);
        exp_state = 9'h000;
        check_quiet("mid_reset_quiet", v0, e0, 0);
        check_all_zero("mid_reset_after");
        v0 = valid_cnt; e0 = err_cnt;
        send_ok(8'h1B);
        exp_state = 9'h040;
        check_key("reset_then_1B", v0, e0, 4'd6, 1'b1);
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_multi_key();
        test_typematic();
        test_extended_break();
        test_parity();
        test_stop_err();
        test_timeout();
        test_reset_mid_frame();
        checks++;
        if (both_cnt !== 0) begin
            failures++;
            $display("FAIL strobe_overlap got=%0d want=0", both_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_key_controller.md
# ps2_key_controller

Receives PS/2 keyboard frames from the raw PS/2 clock/data lines, sequences capture of each 11-bit frame, validates it, and tracks make/break codes for the nine game keys. It converts these keys into a 4-bit key index and a held-key bitmap for the game logic. It sits between the board's PS/2 pins and the game state machines. The index ordering matches the team's existing button encoding: a, d, e, f, g, r, s, t, w map to indices 0–8.

## Interface
- `TIMEOUT_CYCLES`, default 50000: system clocks without a PS/2 falling edge before a partial frame is abandoned. At 50 MHz this is 1 ms.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock from the pin; asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data from the pin; asynchronous to `clk`.
- `key_valid` out 1: single-cycle strobe marking a recognised key event.
- `key_index` out 4: index of the key, 0–8. Valid with `key_valid`; held until the next event.
- `key_pressed` out 1: 1 = make, 0 = break. Valid with `key_valid`; held until the next event.
- `key_state` out 9: bit *i* = 1 while key *i* is held.
- `frame_err` out 1: single-cycle strobe on a stop error, a parity error, or a timeout.

## Operation
- **Synchronisation:** `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser. A falling edge is detected when the sync'd clock was 1 in the previous cycle and is 0 in the current cycle. Data is sampled in the same cycle the falling edge is detected.
- **Frame format:** start bit (0), data[0..7] LSB first, odd parity, stop bit (1).
- **FSM states:** IDLE, RECV, CHECK.
  - IDLE → RECV on a falling edge with data = 0, and the bit counter is set to 1. A falling edge with data = 1 is ignored as a glitch and produces no error.
  - RECV shifts data bits, captures the parity bit, then captures the stop bit. After the 11th bit it goes to CHECK.
  - CHECK lasts exactly one cycle, validates the frame, decodes the byte, and returns to IDLE.
- **Validation in CHECK:**
  - Stop bit 0: `frame_err` pulses and the byte is discarded.
  - Parity failure: handled per Configuration.
- **Decode of a valid byte:**
  - 0xF0 sets `break_pending`. No event is produced.
  - 0xE0 is ignored, and `break_pending` is unchanged.
  - Game-key codes map as follows: 0x1C→0, 0x23→1, 0x24→2, 0x2B→3, 0x34→4, 0x2D→5, 0x1B→6, 0x2C→7, 0x1D→8.
    - On a match: `key_valid`=1, `key_index` is set, and `key_pressed`=!`break_pending`.
    - `key_state[idx]` is set on a make and cleared on a break.
    - `break_pending` is cleared.
  - Any other byte clears `break_pending` and produces no event.
- **Typematic repeats:** a repeated make of a held key still strobes `key_valid`. `key_state` is unchanged.
- **Timeout:** in RECV, an idle counter increments each cycle and resets on each falling edge. When it reaches `TIMEOUT_CYCLES`-1, `frame_err` pulses, the FSM returns to IDLE, and `break_pending` is unchanged.
- **Reset:** FSM=IDLE and the counters are cleared. `break_pending`=0, `key_valid`=0, `key_index`=0, `key_pressed`=0, `key_state`=0, `frame_err`=0. The synchroniser flops reset to 1, the idle-high line level.
- **Reset mid-frame:** the partial frame is lost with no strobe.

## Timing
- Pin-to-edge-detect latency is 3 `clk` cycles.
- `key_valid`/`frame_err` assert in the cycle after CHECK. That is 2 cycles after the cycle in which the 11th falling edge was detected.
- Each strobe lasts exactly 1 cycle.
- `key_state` updates in the same cycle `key_valid` asserts.
- `key_valid` and `frame_err` are never asserted together.
- A timeout `frame_err` asserts exactly `TIMEOUT_CYCLES` cycles after the last falling edge.
- Minimum PS/2 bit period supported: 8 `clk` cycles.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: odd parity over data+parity is checked in CHECK. On failure, `frame_err` pulses, the byte is discarded, and `break_pending` is unchanged.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is shifted in but ignored, and parity failures never raise `frame_err`.

## Test plan
- After reset, drive frame 0x1C (parity 0, stop 1) → one `key_valid` pulse, `key_index`=0, `key_pressed`=1, `key_state`=9'h001.
- Drive 0xF0 then 0x1C → exactly one `key_valid` pulse (after the second frame), `key_pressed`=0, `key_state`=9'h000.
- Drive 0x1D make, 0x23 make, then F0 0x1D → `key_state` goes 9'h100 → 9'h102 → 9'h002.
- With `PS2_PARITY_CHECK_EN`, drive 0x24 with parity bit 0 (wrong) → `frame_err` pulse, no `key_valid`, `key_state` unchanged. Without the macro → `key_valid`, `key_index`=2.
- Send 5 bits of a frame, then stop toggling → `frame_err` exactly `TIMEOUT_CYCLES` cycles after the 5th edge. A following full 0x2B frame → `key_index`=3.
- Assert `reset` midway through a frame and release it, then send 0x1B → no strobe for the partial frame, then `key_index`=6, `key_pressed`=1, all outputs zero in between.
